// File: rtl/uut_test_runner.sv
// uut_test_runner: single-run sequencer that resets, releases and times a block-cipher UUT,
//    then hands result, latencies and timeout flag to the logger over valid/ready.
module uut_test_runner #(
   parameter int BLOCK_W    = 64,
   parameter int KEY_W      = 80,
   parameter int CNT_W      = 32,
   parameter int TIMEOUT    = 1000000,
   parameter int RST_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic               encdec_i,
   input  logic [BLOCK_W-1:0] block_i,
   input  logic [KEY_W-1:0]   key_i,
   output logic               busy,
   output logic               rst_uut,
   output logic [BLOCK_W-1:0] block_i_uut,
   output logic [KEY_W-1:0]   key_uut,
   output logic               encdec_uut,
   input  logic [BLOCK_W-1:0] block_o_uut,
   input  logic               end_key_signal_uut,
   input  logic               end_enc_uut,
   input  logic               end_dec_uut,
   output logic [BLOCK_W-1:0] result_o,
   output logic [CNT_W-1:0]   cycles_o,
   output logic [CNT_W-1:0]   key_cycles_o,
   output logic               timeout_o,
   output logic               result_valid,
   input  logic               result_ready,
   output logic [15:0]        tests_done_o
);
   localparam int RC_W = $clog2(RST_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [RC_W-1:0] ld_q, ld_d;
   logic [BLOCK_W-1:0] blk_q, blk_d, res_q, res_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic enc_q, enc_d, ks_q, ks_d, to_q, to_d, done;
   logic [CNT_W-1:0] cnt_q, cnt_d, kw_q, kw_d, cyc_q, cyc_d, kc_q, kc_d, kfin;
   logic [15:0] tests_q, tests_d;
   assign busy = state_q != IDLE;
   assign rst_uut = state_q == IDLE || state_q == LOAD;
   assign result_valid = state_q == DONE;
   assign block_i_uut = blk_q;
   assign key_uut = key_q;
   assign encdec_uut = enc_q;
   assign result_o = res_q;
   assign cycles_o = cyc_q;
   assign key_cycles_o = kc_q;
   assign timeout_o = to_q;
   assign tests_done_o = tests_q;
   assign done = enc_q ? end_enc_uut : end_dec_uut;
   // the key-schedule pulse may coincide with the final cycle, so fold it in here
   assign kfin = ks_q ? kw_q : (end_key_signal_uut ? cnt_q : '1);
   always_comb begin
      state_d = state_q;
      ld_d = ld_q;
      blk_d = blk_q;
      key_d = key_q;
      enc_d = enc_q;
      cnt_d = cnt_q;
      ks_d = ks_q;
      kw_d = kw_q;
      res_d = res_q;
      cyc_d = cyc_q;
      kc_d = kc_q;
      to_d = to_q;
      tests_d = tests_q;
      if (abort && state_q != IDLE) state_d = IDLE;
      else
         case (state_q)
            IDLE: if (start && !abort) begin
               state_d = LOAD;
               blk_d = block_i;
               key_d = key_i;
               enc_d = encdec_i;
               ld_d = '0;
            end
            LOAD: begin
               cnt_d = CNT_W'(1);
               ks_d = 1'b0;
               ld_d = ld_q + RC_W'(1);
               if (ld_q == RC_W'(RST_CYCLES - 1)) state_d = RUN;
            end
            RUN: begin
               if (end_key_signal_uut && !ks_q) begin
                  ks_d = 1'b1;
                  kw_d = cnt_q;
               end
               if (done || cnt_q == CNT_W'(TIMEOUT)) begin
                  state_d = DONE;
                  res_d = done ? block_o_uut : '0;
                  cyc_d = cnt_q;
                  to_d = !done;
                  kc_d = kfin;
               end else cnt_d = cnt_q + CNT_W'(1);
            end
            DONE: if (result_ready) begin
               state_d = IDLE;
               tests_d = tests_q + 16'd1;
            end
            default: state_d = IDLE;
         endcase
   end
   always_ff @(posedge clk)
      if (rst) begin
         state_q <= IDLE;
         ld_q <= '0;
         blk_q <= '0;
         key_q <= '0;
         enc_q <= 1'b0;
         cnt_q <= '0;
         ks_q <= 1'b0;
         kw_q <= '0;
         res_q <= '0;
         cyc_q <= '0;
         kc_q <= '0;
         to_q <= 1'b0;
         tests_q <= '0;
      end else begin
         state_q <= state_d;
         ld_q <= ld_d;
         blk_q <= blk_d;
         key_q <= key_d;
         enc_q <= enc_d;
         cnt_q <= cnt_d;
         ks_q <= ks_d;
         kw_q <= kw_d;
         res_q <= res_d;
         cyc_q <= cyc_d;
         kc_q <= kc_d;
         to_q <= to_d;
         tests_q <= tests_d;
      end
endmodule

// File: tb/tb_uut_test_runner.sv
// tb_uut_test_runner: randomized runs against a cycle-scripted UUT model; expected
//    results queued at stimulus time and popped by a monitor on each accepted result.
module tb_uut_test_runner;
   localparam int BW = 64, KW = 80, CW = 32, TO = 100, RC = 4;
   logic clk = 0, rst = 1, start = 0, abort = 0, encdec_i = 0, result_ready = 0;
   logic [BW-1:0] block_i = '0, block_i_uut, block_o_uut, result_o;
   logic [KW-1:0] key_i = '0, key_uut;
   logic busy, rst_uut, encdec_uut, end_key_signal_uut, end_enc_uut, end_dec_uut;
   logic timeout_o, result_valid;
   logic [CW-1:0] cycles_o, key_cycles_o;
   logic [15:0] tests_done_o;

   always #5 clk = ~clk;

   uut_test_runner #(.BLOCK_W(BW), .KEY_W(KW), .CNT_W(CW), .TIMEOUT(TO), .RST_CYCLES(RC)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .encdec_i(encdec_i),
      .block_i(block_i), .key_i(key_i), .busy(busy), .rst_uut(rst_uut),
      .block_i_uut(block_i_uut), .key_uut(key_uut), .encdec_uut(encdec_uut),
      .block_o_uut(block_o_uut), .end_key_signal_uut(end_key_signal_uut),
      .end_enc_uut(end_enc_uut), .end_dec_uut(end_dec_uut), .result_o(result_o),
      .cycles_o(cycles_o), .key_cycles_o(key_cycles_o), .timeout_o(timeout_o),
      .result_valid(result_valid), .result_ready(result_ready), .tests_done_o(tests_done_o));

   // UUT model: pulses its outputs on scripted cycles counted from reset release
   int run_cyc = 0, cyc_now, key_at = 0, key_at2 = 0, enc_at = 0, dec_at = 0;
   logic [BW-1:0] data_pat = '0;
   always @(posedge clk) run_cyc <= rst_uut ? 0 : run_cyc + 1;
   assign cyc_now = run_cyc + 1;
   assign end_key_signal_uut = !rst_uut && (cyc_now == key_at || cyc_now == key_at2);
   assign end_enc_uut = !rst_uut && cyc_now == enc_at;
   assign end_dec_uut = !rst_uut && cyc_now == dec_at;
   assign block_o_uut = data_pat;

   typedef struct {
      logic [BW-1:0] res;
      logic [CW-1:0] cyc;
      logic [CW-1:0] kc;
      logic          to;
      logic [15:0]   tests;
   } exp_t;
   exp_t sb[$];
   int vectors = 0, errors = 0, model_tests = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic exp_t predict(input logic ed, input int ka, input int ka2, input int ea,
                                    input int da, input logic [BW-1:0] pat, input int tests);
      exp_t e;
      int d, fin, k;
      d = ed ? ea : da;
      if (d >= 1 && d <= TO) begin
         e.res = pat; e.cyc = CW'(d); e.to = 1'b0; fin = d;
      end else begin
         e.res = '0; e.cyc = CW'(TO); e.to = 1'b1; fin = TO;
      end
      k = -1;
      for (int c = 1; c <= fin; c++)
         if (k < 0 && (c == ka || c == ka2)) k = c;
      e.kc = (k < 0) ? '1 : CW'(k);
      e.tests = tests[15:0];
      return e;
   endfunction

   always begin
      exp_t e;
      @(negedge clk);
      #2;
      if (result_valid && result_ready) begin
         if (sb.size() == 0) begin
            vectors++; errors++;
            $display("FAIL unexpected_result: got result %0h expected none", result_o);
         end else begin
            e = sb.pop_front();
            chk("result_o", result_o, e.res);
            chk("cycles_o", cycles_o, e.cyc);
            chk("key_cycles_o", key_cycles_o, e.kc);
            chk("timeout_o", timeout_o, e.to);
            chk("tests_before", tests_done_o, e.tests);
         end
      end
   end

   task automatic launch(input logic ed, input int ka, input int ka2, input int ea, input int da,
                         input logic [BW-1:0] pat);
      logic [BW-1:0] b;
      logic [KW-1:0] k;
      int n;
      b = {$urandom, $urandom};
      k = {16'($urandom), $urandom, $urandom};
      key_at = ka; key_at2 = ka2; enc_at = ea; dec_at = da; data_pat = pat;
      @(negedge clk);
      start = 1; encdec_i = ed; block_i = b; key_i = k;
      @(negedge clk);
      start = 0; encdec_i = ~ed; block_i = ~b; key_i = ~k;
      chk("busy_after_start", busy, 1);
      chk("rst_uut_load", rst_uut, 1);
      chk("block_i_uut", block_i_uut, b);
      chk("key_uut", key_uut, k);
      chk("encdec_uut", encdec_uut, ed);
      n = 0;
      while (rst_uut && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("load_len", n, RC);
   endtask

   task automatic run(input logic ed, input int ka, input int ka2, input int ea, input int da,
                      input logic [BW-1:0] pat, input int hold);
      exp_t e;
      logic [BW-1:0] r, bl;
      logic [CW-1:0] c, kc;
      int n;
      e = predict(ed, ka, ka2, ea, da, pat, model_tests);
      sb.push_back(e);
      model_tests++;
      launch(ed, ka, ka2, ea, da, pat);
      n = 0;
      while (!result_valid && n < TO + 20) begin
         @(negedge clk);
         n++;
      end
      chk("valid_seen", result_valid, 1);
      chk("valid_latency", n, e.cyc);
      if (hold > 0) begin
         r = result_o; c = cycles_o; kc = key_cycles_o; bl = block_i_uut;
         start = 1;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            start = 0;
            chk("hold_valid", result_valid, 1);
            chk("hold_result", result_o, r);
            chk("hold_cycles", cycles_o, c);
            chk("hold_keycyc", key_cycles_o, kc);
            chk("hold_no_relatch", block_i_uut, bl);
         end
      end
      result_ready = 1;
      @(negedge clk);
      result_ready = 0;
      chk("idle_valid", result_valid, 0);
      chk("idle_rst_uut", rst_uut, 1);
      chk("idle_busy", busy, 0);
      chk("tests_after", tests_done_o, model_tests);
   endtask

   task automatic check_reset_state();
      chk("rst_rst_uut", rst_uut, 1);
      chk("rst_busy", busy, 0);
      chk("rst_valid", result_valid, 0);
      chk("rst_result", result_o, 0);
      chk("rst_cycles", cycles_o, 0);
      chk("rst_keycyc", key_cycles_o, 0);
      chk("rst_timeout", timeout_o, 0);
      chk("rst_tests", tests_done_o, 0);
      chk("rst_block_uut", block_i_uut, 0);
   endtask

   initial begin
      logic [CW-1:0] old_cyc;
      logic ed;
      int ea, da, ka, ka2;
      repeat (3) @(negedge clk);
      check_reset_state();
      rst = 0;
      @(negedge clk);
      start = 1; abort = 1;
      @(negedge clk);
      start = 0; abort = 0;
      chk("start_abort_idle", busy, 0);
      run(1, 32, 0, 33, 0, 64'h1234_5678_9ABC_DEF0, 0);
      run(0, 0, 0, 5, 40, {$urandom, $urandom}, 0);
      run(1, 0, 0, 0, 0, {$urandom, $urandom}, 0);
      run(1, 10, 20, 15, 0, {$urandom, $urandom}, 10);
      old_cyc = cycles_o;
      launch(1, 3, 0, 0, 0, {$urandom, $urandom});
      repeat (6) @(negedge clk);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("abort_busy", busy, 0);
      chk("abort_rst_uut", rst_uut, 1);
      chk("abort_valid", result_valid, 0);
      chk("abort_tests", tests_done_o, model_tests);
      chk("abort_keeps_cycles", cycles_o, old_cyc);
      run(0, 7, 0, 0, 25, {$urandom, $urandom}, 0);
      run(0, 0, 0, 0, TO, {$urandom, $urandom}, 0);
      run(1, TO, 0, TO, 0, {$urandom, $urandom}, 0);
      run(1, 12, 0, 12, 0, {$urandom, $urandom}, 1);
      for (int i = 0; i < 12; i++) begin
         ed = 1'($urandom);
         ea = ($urandom % 4 != 0) ? int'($urandom_range(1, 110)) : 0;
         da = ($urandom % 4 != 0) ? int'($urandom_range(1, 110)) : 0;
         ka = int'($urandom_range(0, 60));
         ka2 = ka != 0 ? ka + int'($urandom_range(1, 30)) : 0;
         run(ed, ka, ka2, ea, da, {$urandom, $urandom}, int'($urandom % 3));
      end
      launch(1, 0, 0, 50, 0, {$urandom, $urandom});
      repeat (5) @(negedge clk);
      rst = 1;
      @(negedge clk);
      check_reset_state();
      rst = 0;
      model_tests = 0;
      run(0, 4, 0, 0, 9, {$urandom, $urandom}, 0);
      chk("scoreboard_drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
